rr_arbiter: RTL and testbench



---
 rtl/rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_rr_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter sharing one resource among N requesters, with a bounded hold under contention.
// Latency: request sampled at edge k shows up as grant after edge k; all outputs registered.
// Backpressure: none; requesters keep request high until granted and for as long as they want ownership.
//
// Ports:
//   clk       single clock, rising edge
//   rst       asynchronous active-low reset
//   request   per-requester request level
//   grant     registered one-hot grant, or all-zero when idle
//   grant_id  index of the current owner, 0 when idle
//   busy      registered |grant
//   preempt   one-cycle pulse with the first grant cycle after a timeout revocation
module rr_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         request,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_id,
   output logic                 busy,
   output logic                 preempt
);

   localparam int IW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

   typedef enum logic {IDLE, GRANTED} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] last_q, last_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [IW-1:0] grant_id_q, grant_id_d;
   logic          busy_q, busy_d;
   logic          preempt_q, preempt_d;

   logic [N-1:0]  others;
   logic [IW:0]   pick_all;
   logic [IW:0]   pick_oth;

   // Returns {found, index}. Scans from + 1, from + 2, ... modulo N; walking the
   // candidates from farthest to nearest lets the nearest hit overwrite the rest.
   function automatic logic [IW:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] from);
      logic [IW:0] res;
      logic [IW:0] sum;
      res = '0;
      for (int i = N; i >= 1; i--) begin
         sum = {1'b0, from} + (IW+1)'(i);
         if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
         if (req[sum[IW-1:0]]) res = {1'b1, sum[IW-1:0]};
      end
      return res;
   endfunction

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      hold_d     = hold_q;
      preempt_d  = 1'b0;
      grant_d    = '0;
      grant_id_d = '0;
      busy_d     = 1'b0;

      // Competitors of the current owner; on a timeout the owner is excluded.
      others   = request & ~(N'(1) << owner_q);
      pick_all = rr_pick(request, last_q);
      pick_oth = rr_pick(others, last_q);

      case (state_q)
         IDLE: begin
            if (pick_all[IW]) begin
               state_d = GRANTED;
               owner_d = pick_all[IW-1:0];
               last_d  = pick_all[IW-1:0];
               hold_d  = HW'(1);
            end
         end
         GRANTED: begin
            if (!request[owner_q]) begin
               // Release: hand off directly, or go idle if nobody else wants it.
               if (pick_oth[IW]) begin
                  owner_d = pick_oth[IW-1:0];
                  last_d  = pick_oth[IW-1:0];
                  hold_d  = HW'(1);
               end else begin
                  state_d = IDLE;
                  hold_d  = '0;
               end
            end else if (hold_q == HOLD_MAX && (|others)) begin
               owner_d   = pick_oth[IW-1:0];
               last_d    = pick_oth[IW-1:0];
               hold_d    = HW'(1);
               preempt_d = 1'b1;
            end else if (hold_q != HOLD_MAX) begin
               // Saturating count: an uncontested owner may hold forever.
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d == GRANTED) begin
         grant_d    = N'(1) << owner_d;
         grant_id_d = owner_d;
         busy_d     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         last_q     <= IW'(N - 1);
         hold_q     <= '0;
         grant_q    <= '0;
         grant_id_q <= '0;
         busy_q     <= 1'b0;
         preempt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         hold_q     <= hold_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         busy_q     <= busy_d;
         preempt_q  <= preempt_d;
      end
   end

   assign grant    = grant_q;
   assign grant_id = grant_id_q;
   assign busy     = busy_q;
   assign preempt  = preempt_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: the driver pushes hand-computed expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] request;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       busy;
   logic       preempt;

   typedef struct packed {
      logic [3:0] g;
      logic [1:0] id;
      logic       b;
      logic       p;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   exp_t  e;
   string t;
   int    n_checks = 0;
   int    n_fail   = 0;

   rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .request  (request),
      .grant    (grant),
      .grant_id (grant_id),
      .busy     (busy),
      .preempt  (preempt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [1:0] idx_of(input logic [3:0] g);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
      return r;
   endfunction

   // Apply request before the edge, then (1 time unit after the edge) apply the
   // reset level and record what the outputs must show before the next edge.
   task automatic step(input logic [3:0] r, input logic rn, input logic [3:0] g,
                       input logic p, input string tag);
      exp_t x;
      request = r;
      @(posedge clk);
      #1;
      rst  = rn;
      x.g  = g;
      x.id = idx_of(g);
      x.b  = |g;
      x.p  = p;
      exp_q.push_back(x);
      tag_q.push_back(tag);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         n_checks++;
         if ({grant, grant_id, busy, preempt} !== {e.g, e.id, e.b, e.p}) begin
            n_fail++;
            $display("FAIL %s: got grant=%b id=%0d busy=%b preempt=%b, want grant=%b id=%0d busy=%b preempt=%b",
                     t, grant, grant_id, busy, preempt, e.g, e.id, e.b, e.p);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b0;
      request = 4'b1111;

      // Reset held with all requests, then released idle.
      step(4'b1111, 1'b0, 4'b0000, 1'b0, "reset_hold");
      step(4'b1111, 1'b0, 4'b0000, 1'b0, "reset_hold");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "reset_release");
      repeat (5) step(4'b0000, 1'b1, 4'b0000, 1'b0, "post_reset_idle");

      // Single requester: grant after the first edge, drop before edge 4.
      step(4'b0010, 1'b1, 4'b0010, 1'b0, "single_grant");
      step(4'b0010, 1'b1, 4'b0010, 1'b0, "single_hold");
      step(4'b0010, 1'b1, 4'b0010, 1'b0, "single_hold");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "single_release");

      // Reset pulse so priority starts at requester 0 again.
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "rot_reset");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "rot_reset_release");

      // Rotation: each owner holds 2 cycles, drops 1, re-raises.
      step(4'b1111, 1'b1, 4'b0001, 1'b0, "rot_g0");
      step(4'b1111, 1'b1, 4'b0001, 1'b0, "rot_g0_hold");
      step(4'b1110, 1'b1, 4'b0010, 1'b0, "rot_g1");
      step(4'b1111, 1'b1, 4'b0010, 1'b0, "rot_g1_hold");
      step(4'b1101, 1'b1, 4'b0100, 1'b0, "rot_g2");
      step(4'b1111, 1'b1, 4'b0100, 1'b0, "rot_g2_hold");
      step(4'b1011, 1'b1, 4'b1000, 1'b0, "rot_g3");
      step(4'b1111, 1'b1, 4'b1000, 1'b0, "rot_g3_hold");
      step(4'b0111, 1'b1, 4'b0001, 1'b0, "rot_wrap_g0");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "rot_idle");

      // Timeout: requester 2 arrives in the 3rd grant cycle; owner 0 keeps 8 cycles.
      repeat (3) step(4'b0001, 1'b1, 4'b0001, 1'b0, "to_owner0");
      repeat (5) step(4'b0101, 1'b1, 4'b0001, 1'b0, "to_owner0_contended");
      step(4'b0101, 1'b1, 4'b0100, 1'b1, "to_preempt");
      step(4'b0101, 1'b1, 4'b0100, 1'b0, "to_after_preempt");
      step(4'b0001, 1'b1, 4'b0001, 1'b0, "to_back_to_0");
      repeat (20) step(4'b0001, 1'b1, 4'b0001, 1'b0, "to_alone_no_preempt");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "to_idle");

      // Hand-off: owner 1 drops, 2 not requesting, 3 wins before 0.
      step(4'b0010, 1'b1, 4'b0010, 1'b0, "ho_owner1");
      step(4'b1011, 1'b1, 4'b0010, 1'b0, "ho_owner1_hold");
      step(4'b1001, 1'b1, 4'b1000, 1'b0, "ho_to_3");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "ho_idle");

      // Reset mid-grant clears outputs before the next edge.
      step(4'b0100, 1'b1, 4'b0100, 1'b0, "mr_owner2");
      step(4'b0100, 1'b0, 4'b0000, 1'b0, "mr_async_clear");
      step(4'b1111, 1'b0, 4'b0000, 1'b0, "mr_reset_hold");
      step(4'b1111, 1'b1, 4'b0000, 1'b0, "mr_reset_release");
      step(4'b1111, 1'b1, 4'b0001, 1'b0, "mr_first_grant");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "mr_idle");

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
